ftrace_sched: RTL and testbench

Function-trace event scheduler between the commit stage and the ftrace DPI sink. It classifies committed JAL/JALR instructions as calls or returns, tracks call depth, and buffers events in a small FIFO. Events drain to the sink over a valid/ready handshake, so a slow sink never stalls the core. Dropped events are counted and reported in-band as an overflow record.

---
 rtl/ftrace_sched.sv | 191 +++++++++++++++++++
 tb/tb_ftrace_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ftrace_sched.sv
// Function-trace event scheduler: turns committed JAL/JALR into call/return
// events tagged with a call depth, buffers them in a small FIFO and drains
// them to the trace sink over valid/ready. Losses are reported in-band as
// an overflow record once the buffered events ahead of them have drained.
module ftrace_sched #(
   parameter logic [3:0] OP_JAL     = 4'd1,
   parameter logic [3:0] OP_JALR    = 4'd0,
   parameter int         FIFO_DEPTH = 8,
   parameter int         DEPTH_W    = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cm_valid,
   input  logic [3:0]         cm_optype,
   input  logic [4:0]         cm_rd,
   input  logic [4:0]         cm_rs1,
   input  logic [31:0]        cm_pc,
   input  logic [31:0]        cm_target,
   output logic               ev_valid,
   input  logic               ev_ready,
   output logic [1:0]         ev_kind,
   output logic [31:0]        ev_pc,
   output logic [31:0]        ev_target,
   output logic [DEPTH_W-1:0] ev_depth,
   output logic [15:0]        drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      OVF
   } state_t;

   typedef struct packed {
      logic [1:0]         kind;
      logic [31:0]        pc;
      logic [31:0]        target;
      logic [DEPTH_W-1:0] depth;
   } entry_t;

   state_t             state;
   state_t             state_next;
   entry_t             mem [FIFO_DEPTH];
   entry_t             head;
   entry_t             new_entry;
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic [AW:0]        wr_ptr_next;
   logic [AW:0]        rd_ptr_next;
   logic [DEPTH_W-1:0] depth;
   logic [DEPTH_W-1:0] depth_inc;
   logic [DEPTH_W-1:0] depth_dec;
   logic [15:0]        drop_cnt_next;
   logic               is_call;
   logic               is_ret;
   logic               classified;
   logic               full;
   logic               empty_next;
   logic               push;
   logic               pop;
   logic               drop;
   logic               ovf_ack;

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   // Classify the committed instruction and build the event it would push.
   // Calls are tagged with the incremented depth, returns with the current
   // one, so a matching pair carries equal tags.
   always_comb begin
      is_call    = cm_valid && ((cm_optype == OP_JAL) || (cm_optype == OP_JALR))
                   && is_link(cm_rd);
      is_ret     = cm_valid && (cm_optype == OP_JALR) && (cm_rd == 5'd0)
                   && is_link(cm_rs1);
      classified = is_call || is_ret;
      depth_inc  = (depth == {DEPTH_W{1'b1}}) ? depth : depth + 1'b1;
      depth_dec  = (depth == '0) ? depth : depth - 1'b1;
      new_entry.kind   = is_call ? 2'b01 : 2'b10;
      new_entry.pc     = cm_pc;
      new_entry.target = cm_target;
      new_entry.depth  = is_call ? depth_inc : depth;
   end

   // FIFO bookkeeping: the extra pointer bit tells full from empty. A pop
   // only happens in SEND, which guarantees the FIFO holds an entry, so a
   // push into a full FIFO succeeds whenever the sink takes the head.
   always_comb begin
      head        = mem[rd_ptr[AW-1:0]];
      full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop         = (state == SEND) && ev_ready;
      ovf_ack     = (state == OVF) && ev_ready;
      push        = classified && (!full || pop);
      drop        = classified && full && !pop;
      wr_ptr_next = wr_ptr + (AW+1)'(push);
      rd_ptr_next = rd_ptr + (AW+1)'(pop);
      empty_next  = (wr_ptr_next == rd_ptr_next);
      drop_cnt_next = drop_cnt;
      if (ovf_ack) begin
         drop_cnt_next = drop ? 16'd1 : 16'd0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt_next = drop_cnt + 16'd1;
      end
   end

   // Event storage; contents are meaningless until the pointers cover them,
   // so the array needs no reset.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= new_entry;
      end
   end

   // Pointers, call depth, drop counter and FSM state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         depth    <= '0;
         drop_cnt <= '0;
         state    <= IDLE;
      end else begin
         wr_ptr   <= wr_ptr_next;
         rd_ptr   <= rd_ptr_next;
         drop_cnt <= drop_cnt_next;
         state    <= state_next;
         if (is_call) begin
            depth <= depth_inc;
         end else if (is_ret) begin
            depth <= depth_dec;
         end
      end
   end

   // Output sequencing: drain buffered events first, and only then report
   // losses, so the overflow record always follows the events before it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!empty_next) begin
               state_next = SEND;
            end else if (drop_cnt != 16'd0) begin
               state_next = OVF;
            end
         end
         SEND: begin
            if (empty_next) begin
               state_next = (drop_cnt_next != 16'd0) ? OVF : IDLE;
            end
         end
         OVF: begin
            if (ovf_ack) begin
               state_next = empty_next ? IDLE : SEND;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Drive the sink interface from the FIFO head or the overflow record.
   always_comb begin
      ev_valid  = 1'b0;
      ev_kind   = 2'b00;
      ev_pc     = 32'd0;
      ev_target = 32'd0;
      ev_depth  = '0;
      case (state)
         SEND: begin
            ev_valid  = 1'b1;
            ev_kind   = head.kind;
            ev_pc     = head.pc;
            ev_target = head.target;
            ev_depth  = head.depth;
         end
         OVF: begin
            ev_valid  = 1'b1;
            ev_kind   = 2'b11;
            ev_pc     = 32'd0;
            ev_target = {16'd0, drop_cnt};
            ev_depth  = depth;
         end
         default: begin
            ev_valid  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ftrace_sched.sv
// Directed self-checking bench for ftrace_sched: call/return pairing,
// ignored jumps, overflow accounting, depth saturation at zero, stall
// stability and mid-stream reset.
module tb_ftrace_sched;

   localparam logic [3:0] JAL  = 4'd1;
   localparam logic [3:0] JALR = 4'd0;

   logic        clock;
   logic        reset;
   logic        cm_valid;
   logic [3:0]  cm_optype;
   logic [4:0]  cm_rd;
   logic [4:0]  cm_rs1;
   logic [31:0] cm_pc;
   logic [31:0] cm_target;
   logic        ev_valid;
   logic        ev_ready;
   logic [1:0]  ev_kind;
   logic [31:0] ev_pc;
   logic [31:0] ev_target;
   logic [7:0]  ev_depth;
   logic [15:0] drop_cnt;

   int n_compared;
   int n_mismatched;

   ftrace_sched #(
      .OP_JAL(JAL),
      .OP_JALR(JALR),
      .FIFO_DEPTH(8),
      .DEPTH_W(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .cm_valid(cm_valid),
      .cm_optype(cm_optype),
      .cm_rd(cm_rd),
      .cm_rs1(cm_rs1),
      .cm_pc(cm_pc),
      .cm_target(cm_target),
      .ev_valid(ev_valid),
      .ev_ready(ev_ready),
      .ev_kind(ev_kind),
      .ev_pc(ev_pc),
      .ev_target(ev_target),
      .ev_depth(ev_depth),
      .drop_cnt(drop_cnt)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Present one commit for exactly one clock; returns 1 time unit after the edge.
   task automatic applyStimulus(input logic [3:0] optype, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [31:0] pc,
                                input logic [31:0] target);
      cm_valid  = 1'b1;
      cm_optype = optype;
      cm_rd     = rd;
      cm_rs1    = rs1;
      cm_pc     = pc;
      cm_target = target;
      @(posedge clock);
      #1;
      cm_valid  = 1'b0;
   endtask

   // Hold reset for one clock and release it just after the edge.
   task automatic pulseReset();
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic checkEvent(input string tag, input logic [1:0] kind,
                             input logic [31:0] pc, input logic [31:0] target,
                             input logic [7:0] depth);
      checkOutput({tag, ".valid"},  64'(ev_valid),  64'd1);
      checkOutput({tag, ".kind"},   64'(ev_kind),   64'(kind));
      checkOutput({tag, ".pc"},     64'(ev_pc),     64'(pc));
      checkOutput({tag, ".target"}, 64'(ev_target), 64'(target));
      checkOutput({tag, ".depth"},  64'(ev_depth),  64'(depth));
   endtask

   // Directed sequence of scenarios.
   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      reset     = 1'b0;
      cm_valid  = 1'b0;
      cm_optype = 4'd0;
      cm_rd     = 5'd0;
      cm_rs1    = 5'd0;
      cm_pc     = 32'd0;
      cm_target = 32'd0;
      ev_ready  = 1'b0;
      #1;
      checkOutput("rst.valid",  64'(ev_valid),  64'd0);
      checkOutput("rst.kind",   64'(ev_kind),   64'd0);
      checkOutput("rst.pc",     64'(ev_pc),     64'd0);
      checkOutput("rst.target", 64'(ev_target), 64'd0);
      checkOutput("rst.depth",  64'(ev_depth),  64'd0);
      checkOutput("rst.drop",   64'(drop_cnt),  64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Call then return with the sink always ready.
      ev_ready = 1'b1;
      applyStimulus(JAL, 5'd1, 5'd0, 32'h8000_0000, 32'h8000_0100);
      checkEvent("call1", 2'b01, 32'h8000_0000, 32'h8000_0100, 8'd1);
      applyStimulus(JALR, 5'd0, 5'd1, 32'h8000_0104, 32'h8000_0004);
      checkEvent("ret1", 2'b10, 32'h8000_0104, 32'h8000_0004, 8'd1);
      @(posedge clock);
      #1;
      checkOutput("ret1.drained", 64'(ev_valid), 64'd0);

      // Plain jumps produce nothing.
      applyStimulus(JAL, 5'd0, 5'd0, 32'h100, 32'h200);
      checkOutput("plain_jal.valid", 64'(ev_valid), 64'd0);
      applyStimulus(JALR, 5'd0, 5'd2, 32'h104, 32'h300);
      checkOutput("plain_jalr.valid", 64'(ev_valid), 64'd0);
      applyStimulus(4'd5, 5'd1, 5'd1, 32'h108, 32'h400);
      checkOutput("nonjump.valid", 64'(ev_valid), 64'd0);

      // Return at depth 0 does not underflow; following call is depth 1.
      pulseReset();
      applyStimulus(JALR, 5'd0, 5'd5, 32'h500, 32'h600);
      checkEvent("ret0", 2'b10, 32'h500, 32'h600, 8'd0);
      applyStimulus(JALR, 5'd5, 5'd0, 32'h504, 32'h700);
      checkEvent("call_after_ret0", 2'b01, 32'h504, 32'h700, 8'd1);
      @(posedge clock);
      #1;

      // Backpressure: 10 calls into an 8-entry FIFO.
      pulseReset();
      ev_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(JAL, 5'd1, 5'd0, 32'h1000 + 32'(4 * i), 32'h2000 + 32'(i));
      end
      checkOutput("ovf.drop_cnt", 64'(drop_cnt), 64'd2);
      ev_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkEvent($sformatf("ovf.ev%0d", i), 2'b01, 32'h1000 + 32'(4 * i),
                    32'h2000 + 32'(i), 8'(i + 1));
         @(posedge clock);
         #1;
      end
      checkEvent("ovf.record", 2'b11, 32'd0, 32'd2, 8'd10);
      @(posedge clock);
      #1;
      checkOutput("ovf.after.valid", 64'(ev_valid), 64'd0);
      checkOutput("ovf.after.drop",  64'(drop_cnt), 64'd0);

      // Stall stability with ev_ready toggling each cycle.
      pulseReset();
      ev_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(JAL, 5'd5, 5'd0, 32'h3000 + 32'(16 * i), 32'h4000 + 32'(i));
      end
      for (int k = 0; k < 4; k++) begin
         ev_ready = 1'b0;
         checkEvent($sformatf("stall%0d.a", k), 2'b01, 32'h3000 + 32'(16 * k),
                    32'h4000 + 32'(k), 8'(k + 1));
         @(posedge clock);
         #1;
         checkEvent($sformatf("stall%0d.b", k), 2'b01, 32'h3000 + 32'(16 * k),
                    32'h4000 + 32'(k), 8'(k + 1));
         ev_ready = 1'b1;
         @(posedge clock);
         #1;
      end
      checkOutput("stall.drained", 64'(ev_valid), 64'd0);

      // Reset in the middle of buffered traffic.
      pulseReset();
      ev_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(JAL, 5'd1, 5'd0, 32'h5000 + 32'(4 * i), 32'h6000);
      end
      checkOutput("midrst.pre.valid", 64'(ev_valid), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("midrst.valid", 64'(ev_valid), 64'd0);
      checkOutput("midrst.drop",  64'(drop_cnt), 64'd0);
      checkOutput("midrst.pc",    64'(ev_pc),    64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("midrst.empty", 64'(ev_valid), 64'd0);
      ev_ready = 1'b1;
      applyStimulus(JAL, 5'd1, 5'd0, 32'h7000, 32'h7100);
      checkEvent("midrst.call", 2'b01, 32'h7000, 32'h7100, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
